// File: rtl/preproc_seq_pkg.sv
// Shared types and constants for the Preprocessor front-end sequencer.
//   state_t  : sequencer FSM states (warm-up, steady run, history flush)
//   NUM_WIN  : number of averaging windows tracked for warm-up
//   WIN_LEN  : window lengths; entries 0..5 are the SMAs, entry 6 is sqr_mean
package preproc_seq_pkg;

    typedef enum logic [1:0] {
        ST_WARMUP = 2'd0,
        ST_RUN    = 2'd1,
        ST_FLUSH  = 2'd2
    } state_t;

    localparam int NUM_WIN = 7;
    localparam int WIN_LEN [NUM_WIN] = '{5, 10, 20, 50, 100, 200, 20};

endpackage

// File: rtl/preproc_sequencer_if.sv
// Tick handshake and instrument-switch handshake between the market-data
// decoder (master) and the sequencer (slave).
//   tick_valid/tick_price/tick_ready : valid/ready price stream
//   switch_req/switch_ack            : level flush request, completion pulse
interface preproc_sequencer_if;

    logic       tick_valid;
    logic [7:0] tick_price;
    logic       tick_ready;
    logic       switch_req;
    logic       switch_ack;

    modport master (
        output tick_valid, tick_price, switch_req,
        input  tick_ready, switch_ack
    );

    modport slave (
        input  tick_valid, tick_price, switch_req,
        output tick_ready, switch_ack
    );

endinterface

// File: rtl/preproc_sequencer_warmup_tracker.sv
// Saturating warm-up counter plus the per-window "history is full" flags.
//   clk, rst   : clock, asynchronous active-low reset
//   clear      : force the counter (and all flags) to zero
//   enable     : advance the counter by one this cycle
//   warm_cnt   : samples seen since the first tick, saturating at MAX_WIN+SMA_LAT
//   win_valid  : bit i set once warm_cnt >= WIN_LEN[i]+SMA_LAT
module warmup_tracker
    import preproc_seq_pkg::*;
#(
    parameter int SMA_LAT = 1,
    parameter int MAX_WIN = 200,
    parameter int CNT_W   = 9
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               enable,
    output logic [CNT_W-1:0]   warm_cnt,
    output logic [NUM_WIN-1:0] win_valid
);

    localparam logic [CNT_W-1:0] SAT_VAL = CNT_W'(MAX_WIN + SMA_LAT);

    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [NUM_WIN-1:0] win_valid_q, win_valid_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear)
            cnt_d = '0;
        else if (enable && (cnt_q != SAT_VAL))
            cnt_d = cnt_q + 1'b1;
    end

    // Flags are compared against the next count so they line up with warm_cnt.
    for (genvar gi = 0; gi < NUM_WIN; gi++) begin : g_win
        assign win_valid_d[gi] = (cnt_d >= CNT_W'(WIN_LEN[gi] + SMA_LAT));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q       <= '0;
            win_valid_q <= '0;
        end else begin
            cnt_q       <= cnt_d;
            win_valid_q <= win_valid_d;
        end
    end

    assign warm_cnt  = cnt_q;
    assign win_valid = win_valid_q;

endmodule

// File: rtl/preproc_sequencer.sv
// Front-end controller for the Preprocessor SMA / second-moment datapath.
// Accepts sporadic ticks, drives the held price into the Preprocessor every
// clock, tracks window warm-up, and flushes all window histories with zeros
// on an instrument switch.
//   clk, rst    : clock, asynchronous active-low reset
//   tick_if     : tick valid/ready stream and switch_req/switch_ack
//   pp_data_in  : registered drive to Preprocessor data_in
//   feat_valid  : pulse when Preprocessor outputs reflect a new tick
//   win_valid   : per-window warm-up complete (SMA 5..200, sqr_mean 20)
//   busy        : flush in progress
module preproc_sequencer
    import preproc_seq_pkg::*;
#(
    parameter int SMA_LAT = 1,
    parameter int MAX_WIN = 200,
    parameter int CNT_W   = 9
) (
    input  logic                clk,
    input  logic                rst,
    preproc_sequencer_if.slave  tick_if,
    output logic [7:0]          pp_data_in,
    output logic                feat_valid,
    output logic [NUM_WIN-1:0]  win_valid,
    output logic                busy
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_WIN + SMA_LAT - 1);

    state_t             state_q, state_d;
    logic [7:0]         pp_q, pp_d;
    logic               first_seen_q, first_seen_d;
    logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;
    logic               ack_q, ack_d;
    logic [SMA_LAT:0]   feat_sr_q, feat_sr_d;

    logic               accept;
    logic               enter_flush;
    logic               cnt_en;
    logic [CNT_W-1:0]   warm_cnt;

    // A pending switch blocks ticks so no price lands in the fresh histories.
    assign tick_if.tick_ready = (state_q != ST_FLUSH) && !tick_if.switch_req;
    assign accept      = tick_if.tick_valid && tick_if.tick_ready;
    assign enter_flush = (state_q != ST_FLUSH) && tick_if.switch_req;
    // Every held cycle is a sample, so counting starts at the acceptance edge.
    assign cnt_en      = !enter_flush && (state_q != ST_FLUSH) && (first_seen_q || accept);

    warmup_tracker #(
        .SMA_LAT (SMA_LAT),
        .MAX_WIN (MAX_WIN),
        .CNT_W   (CNT_W)
    ) u_warmup (
        .clk       (clk),
        .rst       (rst),
        .clear     (enter_flush),
        .enable    (cnt_en),
        .warm_cnt  (warm_cnt),
        .win_valid (win_valid)
    );

    always_comb begin
        state_d      = state_q;
        pp_d         = pp_q;
        first_seen_d = first_seen_q;
        flush_cnt_d  = flush_cnt_q;
        ack_d        = 1'b0;
        // feat_sr_q[0] marks the cycle pp_data_in first shows the price; the
        // remaining SMA_LAT stages cover the Preprocessor latency.
        feat_sr_d    = {feat_sr_q[SMA_LAT-1:0], accept};

        if (enter_flush) begin
            state_d      = ST_FLUSH;
            pp_d         = '0;
            first_seen_d = 1'b0;
            flush_cnt_d  = '0;
            feat_sr_d    = '0;
        end else begin
            if (accept) begin
                pp_d         = tick_if.tick_price;
                first_seen_d = 1'b1;
            end
            case (state_q)
                ST_WARMUP: begin
                    if (cnt_en && (warm_cnt >= LAST_CNT))
                        state_d = ST_RUN;
                end
                ST_RUN: begin
                    state_d = ST_RUN;
                end
                ST_FLUSH: begin
                    if (flush_cnt_q >= LAST_CNT) begin
                        state_d = ST_WARMUP;
                        ack_d   = 1'b1;
                    end else begin
                        flush_cnt_d = flush_cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = ST_WARMUP;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_WARMUP;
            pp_q         <= '0;
            first_seen_q <= 1'b0;
            flush_cnt_q  <= '0;
            ack_q        <= 1'b0;
            feat_sr_q    <= '0;
        end else begin
            state_q      <= state_d;
            pp_q         <= pp_d;
            first_seen_q <= first_seen_d;
            flush_cnt_q  <= flush_cnt_d;
            ack_q        <= ack_d;
            feat_sr_q    <= feat_sr_d;
        end
    end

    assign pp_data_in         = pp_q;
    assign feat_valid         = feat_sr_q[SMA_LAT];
    assign busy               = (state_q == ST_FLUSH);
    assign tick_if.switch_ack = ack_q;

endmodule

// File: tb/tb_preproc_sequencer.sv
// Directed bench for preproc_sequencer (SMA_LAT=1, MAX_WIN=200).
module tb_preproc_sequencer;
    import preproc_seq_pkg::*;

    logic       clk;
    logic       rst;
    logic [7:0] pp_data_in;
    logic       feat_valid;
    logic [6:0] win_valid;
    logic       busy;

    int n_vec = 0;
    int n_err = 0;

    preproc_sequencer_if tif();

    preproc_sequencer #(
        .SMA_LAT (1),
        .MAX_WIN (200),
        .CNT_W   (9)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .tick_if    (tif),
        .pp_data_in (pp_data_in),
        .feat_valid (feat_valid),
        .win_valid  (win_valid),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL timeout: observed no finish, expected finish");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        int busy_cnt, ack_cnt, ack_at, nz, bad_pp, bad_feat, bad_warm, exp_warm;
        logic [7:0] price;

        rst = 1'b0;
        tif.tick_valid = 1'b0;
        tif.tick_price = '0;
        tif.switch_req = 1'b0;

        // Reset state
        #12;
        check("rst_pp", 32'(pp_data_in), 32'd0);
        check("rst_feat", 32'(feat_valid), 32'd0);
        check("rst_win", 32'(win_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ack", 32'(tif.switch_ack), 32'd0);
        rst = 1'b1;

        // Single tick 100, then hold
        tif.tick_valid = 1'b1;
        tif.tick_price = 8'd100;
        #1;
        check("t1_ready", 32'(tif.tick_ready), 32'd1);
        step();
        tif.tick_valid = 1'b0;
        check("t1_pp_e0", 32'(pp_data_in), 32'd100);
        check("t1_feat_e0", 32'(feat_valid), 32'd0);
        check("t1_warm_e0", 32'(dut.warm_cnt), 32'd1);
        step();
        check("t1_feat_e1", 32'(feat_valid), 32'd1);
        check("t1_warm_e1", 32'(dut.warm_cnt), 32'd2);
        for (int w = 3; w <= 205; w++) begin
            step();
            case (w)
                3:   check("t1_feat_e2", 32'(feat_valid), 32'd0);
                5:   check("t1_win_5", 32'(win_valid), 32'h00);
                6:   check("t1_win_6", 32'(win_valid), 32'h01);
                10:  check("t1_win_10", 32'(win_valid), 32'h01);
                11:  check("t1_win_11", 32'(win_valid), 32'h03);
                20:  check("t1_win_20", 32'(win_valid), 32'h03);
                21:  check("t1_win_21", 32'(win_valid), 32'h47);
                51:  check("t1_win_51", 32'(win_valid), 32'h4F);
                101: check("t1_win_101", 32'(win_valid), 32'h5F);
                200: begin
                    check("t1_win_200", 32'(win_valid), 32'h5F);
                    check("t1_state_200", 32'(dut.state_q), 32'(ST_WARMUP));
                end
                201: begin
                    check("t1_win_201", 32'(win_valid), 32'h7F);
                    check("t1_state_201", 32'(dut.state_q), 32'(ST_RUN));
                end
                205: begin
                    check("t1_warm_sat", 32'(dut.warm_cnt), 32'd201);
                    check("t1_pp_hold", 32'(pp_data_in), 32'd100);
                end
                default: ;
            endcase
        end

        // Back-to-back ticks 10, 20, 30
        tif.tick_valid = 1'b1;
        tif.tick_price = 8'd10;
        step();
        check("t2_pp10", 32'(pp_data_in), 32'd10);
        check("t2_feat0", 32'(feat_valid), 32'd0);
        tif.tick_price = 8'd20;
        step();
        check("t2_pp20", 32'(pp_data_in), 32'd20);
        check("t2_feat1", 32'(feat_valid), 32'd1);
        tif.tick_price = 8'd30;
        step();
        check("t2_pp30", 32'(pp_data_in), 32'd30);
        check("t2_feat2", 32'(feat_valid), 32'd1);
        tif.tick_valid = 1'b0;
        step();
        check("t2_pp_hold", 32'(pp_data_in), 32'd30);
        check("t2_feat3", 32'(feat_valid), 32'd1);
        step();
        check("t2_feat_end", 32'(feat_valid), 32'd0);

        // Switch in RUN beats a simultaneous tick
        tif.switch_req = 1'b1;
        tif.tick_valid = 1'b1;
        tif.tick_price = 8'd55;
        #1;
        check("t3_ready", 32'(tif.tick_ready), 32'd0);
        step();
        tif.switch_req = 1'b0;
        tif.tick_valid = 1'b0;
        check("t3_pp", 32'(pp_data_in), 32'd0);
        check("t3_busy", 32'(busy), 32'd1);
        check("t3_win", 32'(win_valid), 32'd0);
        check("t3_warm", 32'(dut.warm_cnt), 32'd0);
        busy_cnt = 1; ack_cnt = 0; ack_at = -1; nz = 0;
        for (int i = 1; i <= 205; i++) begin
            step();
            if (busy) busy_cnt++;
            if (tif.switch_ack) begin ack_cnt++; ack_at = i; end
            if (pp_data_in != 8'd0) nz++;
        end
        check("t3_busy_cycles", 32'(busy_cnt), 32'd201);
        check("t3_ack_count", 32'(ack_cnt), 32'd1);
        check("t3_ack_edge", 32'(ack_at), 32'd201);
        check("t3_pp_zero", 32'(nz), 32'd0);
        check("t3_state", 32'(dut.state_q), 32'(ST_WARMUP));
        check("t3_warm_end", 32'(dut.warm_cnt), 32'd0);

        // Tick then switch on the next edge: its feature is purged
        tif.tick_valid = 1'b1;
        tif.tick_price = 8'd77;
        step();
        check("t4_pp", 32'(pp_data_in), 32'd77);
        tif.tick_valid = 1'b0;
        tif.switch_req = 1'b1;
        step();
        tif.switch_req = 1'b0;
        check("t4_feat_a", 32'(feat_valid), 32'd0);
        check("t4_busy", 32'(busy), 32'd1);
        check("t4_pp0", 32'(pp_data_in), 32'd0);
        step();
        check("t4_feat_b", 32'(feat_valid), 32'd0);

        // Asynchronous reset at flush cycle 50
        repeat (49) step();
        check("t5_busy_pre", 32'(busy), 32'd1);
        rst = 1'b0;
        #1;
        check("t5_pp", 32'(pp_data_in), 32'd0);
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_feat", 32'(feat_valid), 32'd0);
        check("t5_ack", 32'(tif.switch_ack), 32'd0);
        check("t5_win", 32'(win_valid), 32'd0);
        step();
        rst = 1'b1;
        #1;
        check("t5_ready", 32'(tif.tick_ready), 32'd1);
        check("t5_state", 32'(dut.state_q), 32'(ST_WARMUP));
        ack_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (tif.switch_ack || busy) ack_cnt++;
        end
        check("t5_no_ack", 32'(ack_cnt), 32'd0);

        // switch_req held through the ack restarts a flush
        tif.switch_req = 1'b1;
        #1;
        check("t7_ready", 32'(tif.tick_ready), 32'd0);
        step();
        repeat (200) step();
        check("t7_busy_last", 32'(busy), 32'd1);
        check("t7_ack_early", 32'(tif.switch_ack), 32'd0);
        step();
        check("t7_busy_exit", 32'(busy), 32'd0);
        check("t7_ack", 32'(tif.switch_ack), 32'd1);
        step();
        check("t7_reflush", 32'(busy), 32'd1);
        check("t7_ack_off", 32'(tif.switch_ack), 32'd0);
        tif.switch_req = 1'b0;
        repeat (200) step();
        step();
        check("t7_ack2", 32'(tif.switch_ack), 32'd1);

        // 1000 cycles of continuous ticks
        bad_pp = 0; bad_feat = 0; bad_warm = 0;
        tif.tick_valid = 1'b1;
        for (int j = 0; j < 1000; j++) begin
            price = 8'((j * 7 + 3) & 255);
            tif.tick_price = price;
            step();
            exp_warm = (j + 1 > 201) ? 201 : j + 1;
            if (pp_data_in != price) bad_pp++;
            if (j >= 1 && !feat_valid) bad_feat++;
            if (32'(dut.warm_cnt) != 32'(exp_warm)) bad_warm++;
        end
        tif.tick_valid = 1'b0;
        check("t6_pp_follow", 32'(bad_pp), 32'd0);
        check("t6_feat_every", 32'(bad_feat), 32'd0);
        check("t6_warm_track", 32'(bad_warm), 32'd0);
        check("t6_warm_sat", 32'(dut.warm_cnt), 32'd201);
        check("t6_win", 32'(win_valid), 32'h7F);
        check("t6_state", 32'(dut.state_q), 32'(ST_RUN));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
